// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Single-port data-memory responder for a multi-cycle core. It accepts one
// load or store at a time. It holds the request for a fixed number of BUSY
// cycles and then performs the access. Completion is signalled with a
// one-cycle write_done pulse.
//
// Ports
//   clk           : the only clock; all state changes on its rising edge
//   reset         : synchronous, active-high; abandons any access in flight
//   memory_read   : load request from the core
//   memory_write  : store request (wins when both requests are high)
//   address       : byte address; bits [11:2] select the word, [1:0] ignored
//   write_data    : lane-aligned store data
//   write_mask    : byte-lane enables, bit i covers write_data[8i+7:8i]
//   read_data     : registered load data, held until the next completed read
//   write_done    : one-cycle completion pulse for any access
//   busy          : high while an access is in flight (BUSY or DONE)
//   access_fault  : high with write_done when the access was out of range
// ----------------------------------------------------------------------------
module dmem_responder #(
   parameter int LATENCY     = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_read,
   input  logic        memory_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_mask,
   output logic [31:0] read_data,
   output logic        write_done,
   output logic        busy,
   output logic        access_fault
);

   localparam int         IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] COUNT_LOAD  = 4'(LATENCY - 1);
   localparam logic [10:0] DEPTH_LIMIT = 11'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [3:0]  count_r;
   logic [3:0]  next_count_s;
   logic        accept_s;
   logic        commit_s;
   logic        fault_s;
   logic        mem_we_s;

   // Request captured at accept; the core may change its outputs afterwards
   logic        op_write_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wmask_r;

   logic [31:0] read_data_r;
   logic        write_done_r;
   logic        busy_r;
   logic        access_fault_r;

   logic [9:0]  word_sel_s;
   logic [31:0] mem_word_s;
   logic [31:0] mem_r [DEPTH_WORDS];

   // Byte offset is resolved upstream by the lane logic, so it is never used here
   logic        unused_s;

   assign unused_s   = ^addr_r[1:0];
   assign word_sel_s = addr_r[11:2];
   // Anything above the 4 KiB window, or beyond a smaller configured depth, faults
   assign fault_s    = (addr_r[31:12] != 20'd0) || ({1'b0, word_sel_s} >= DEPTH_LIMIT);
   assign mem_word_s = mem_r[word_sel_s[IDX_W-1:0]];

   // Next-state, counter and access strobes
   always_comb begin
      next_state_s = state_r;
      next_count_s = count_r;
      accept_s     = 1'b0;
      commit_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (memory_read || memory_write) begin
               accept_s     = 1'b1;
               next_state_s = BUSY;
               next_count_s = COUNT_LOAD;
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY: begin
            if (count_r == 4'd0) begin
               commit_s     = 1'b1;
               next_state_s = DONE;
            end else begin
               next_count_s = count_r - 4'd1;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
            next_count_s = 4'd0;
         end
      endcase
   end

   // A reset on the commit edge discards the store together with the access
   assign mem_we_s = commit_s && op_write_r && !fault_s && !reset;

   // FSM state, request capture and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         count_r        <= 4'd0;
         write_done_r   <= 1'b0;
         access_fault_r <= 1'b0;
         busy_r         <= 1'b0;
         read_data_r    <= 32'h0000_0000;
      end else begin
         state_r        <= next_state_s;
         count_r        <= next_count_s;
         busy_r         <= (next_state_s != IDLE);
         write_done_r   <= commit_s;
         access_fault_r <= commit_s && fault_s;
         if (accept_s) begin
            // Store wins when both requests are raised together
            op_write_r <= memory_write;
            addr_r     <= address;
            wdata_r    <= write_data;
            wmask_r    <= write_mask;
         end
         if (commit_s && !op_write_r) begin
            read_data_r <= fault_s ? 32'h0000_0000 : mem_word_s;
         end
      end
   end

   // Storage array with per-lane write enables; reset leaves contents alone
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_r[b]) begin
               mem_r[word_sel_s[IDX_W-1:0]][8*b +: 8] <= wdata_r[8*b +: 8];
            end
         end
      end
   end

   assign read_data    = read_data_r;
   assign write_done   = write_done_r;
   assign busy         = busy_r;
   assign access_fault = access_fault_r;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. The main instance uses
// LATENCY=2, and a second instance uses LATENCY=1 for the back-to-back
// cadence. Expected values come from a word-array model of storage, a tracked
// copy of the last load result, and the fixed request-to-done timeline.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        memory_read;
   logic        memory_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [3:0]  write_mask;
   logic [31:0] read_data;
   logic        write_done;
   logic        busy;
   logic        access_fault;

   logic        memory_read1;
   logic [31:0] unused_rdata1;
   logic        write_done1;
   logic        busy1;
   logic        access_fault1;

   // Model: the first 64 words of storage plus the value read_data must show
   logic [31:0] model_mem [64];
   logic [31:0] exp_rd;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(1024)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .memory_read  (memory_read),
      .memory_write (memory_write),
      .address      (address),
      .write_data   (write_data),
      .write_mask   (write_mask),
      .read_data    (read_data),
      .write_done   (write_done),
      .busy         (busy),
      .access_fault (access_fault)
   );

   dmem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) u_dut_l1 (
      .clk          (clk),
      .reset        (reset),
      .memory_read  (memory_read1),
      .memory_write (1'b0),
      .address      (32'h0000_0000),
      .write_data   (32'h0000_0000),
      .write_mask   (4'h0),
      .read_data    (unused_rdata1),
      .write_done   (write_done1),
      .busy         (busy1),
      .access_fault (access_fault1)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_junk();
      memory_read  = 1'($urandom);
      memory_write = 1'($urandom);
      address      = $urandom;
      write_data   = $urandom;
      write_mask   = 4'($urandom);
   endtask

   // One complete access. The request is presented in the current cycle c0.
   // busy is checked in c1..cLAT. write_done and data are checked in
   // c(LAT+1). The final check falls in the following IDLE cycle. The task
   // drives random requests into BUSY and DONE; the DUT must ignore them.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
      logic        is_fault;
      logic [31:0] merged;
      int          w;
      memory_read  = rd;
      memory_write = wr;
      address      = addr;
      write_data   = data;
      write_mask   = mask;
      is_fault     = (addr[31:12] != 20'd0);
      w            = int'(addr[7:2]);
      step();
      for (int k = 0; k < LAT; k++) begin
         chk_eq("busy_in_flight", 32'(busy), 32'd1);
         chk_eq("done_early", 32'(write_done), 32'd0);
         chk_eq("fault_early", 32'(access_fault), 32'd0);
         drive_junk();
         step();
      end
      if (wr) begin
         if (!is_fault) begin
            merged = model_mem[w];
            for (int b = 0; b < 4; b++) begin
               if (mask[b]) merged[8*b +: 8] = data[8*b +: 8];
            end
            model_mem[w] = merged;
         end
      end else begin
         exp_rd = is_fault ? 32'd0 : model_mem[w];
      end
      chk_eq("done_pulse", 32'(write_done), 32'd1);
      chk_eq("fault_flag", 32'(access_fault), 32'(is_fault));
      chk_eq("busy_done", 32'(busy), 32'd1);
      chk_eq("read_data_done", read_data, exp_rd);
      drive_junk();
      step();
      chk_eq("done_single", 32'(write_done), 32'd0);
      chk_eq("fault_idle", 32'(access_fault), 32'd0);
      chk_eq("busy_idle", 32'(busy), 32'd0);
      chk_eq("read_data_hold", read_data, exp_rd);
      memory_read  = 1'b0;
      memory_write = 1'b0;
   endtask

   initial begin
      logic [31:0] prev_rd;
      logic [31:0] a;
      int          op;

      reset        = 1'b1;
      memory_read  = 1'b0;
      memory_write = 1'b0;
      memory_read1 = 1'b0;
      address      = 32'd0;
      write_data   = 32'd0;
      write_mask   = 4'h0;
      exp_rd       = 32'd0;
      step();
      step();
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_done", 32'(write_done), 32'd0);
      chk_eq("rst_fault", 32'(access_fault), 32'd0);
      chk_eq("rst_rdata", read_data, 32'd0);

      // A request on a reset edge is not accepted
      memory_write = 1'b1;
      address      = 32'h0000_0020;
      write_data   = 32'hFFFF_FFFF;
      write_mask   = 4'hF;
      step();
      reset        = 1'b0;
      memory_write = 1'b0;
      chk_eq("rst_override_busy", 32'(busy), 32'd0);
      step();
      chk_eq("rst_override_busy2", 32'(busy), 32'd0);
      chk_eq("rst_override_done", 32'(write_done), 32'd0);

      // Give the 64 modelled words known contents
      for (int i = 0; i < 64; i++) begin
         access(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
      end

      // Full-word write then read back
      access(1'b0, 1'b1, 32'h0000_0040, 32'hABAD_BABE, 4'hF);
      access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
      chk_eq("rd_abadbabe", read_data, 32'hABAD_BABE);

      // Partial-lane merge
      access(1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF);
      access(1'b0, 1'b1, 32'h0000_0040, 32'hAA00_00BB, 4'b1001);
      access(1'b1, 1'b0, 32'h0000_0041, 32'h0, 4'h0);
      chk_eq("merge_1001", read_data, 32'hAA22_33BB);

      // Read and write together act as a write
      prev_rd = exp_rd;
      access(1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'hF);
      chk_eq("both_keeps_rdata", read_data, prev_rd);
      access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
      chk_eq("both_wrote", read_data, 32'hDEAD_BEEF);

      // Out-of-range read faults and returns zero
      access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
      chk_eq("fault_rdata_zero", read_data, 32'd0);

      // Reset in the first BUSY cycle drops the store
      access(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF);
      memory_write = 1'b1;
      address      = 32'h0000_0010;
      write_data   = 32'h5555_5555;
      write_mask   = 4'hF;
      step();
      chk_eq("abort_busy_before", 32'(busy), 32'd1);
      memory_write = 1'b0;
      reset        = 1'b1;
      step();
      reset  = 1'b0;
      exp_rd = 32'd0;
      chk_eq("abort_busy_after", 32'(busy), 32'd0);
      chk_eq("abort_rdata", read_data, 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk_eq("abort_no_done", 32'(write_done), 32'd0);
         step();
      end
      access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      chk_eq("abort_word_kept", read_data, 32'h0000_0000);

      // Randomised traffic against the model
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            a = {20'($urandom_range(1, 20'hF_FFFF)), 12'($urandom)};
         end else begin
            a = {24'd0, 6'($urandom), 2'($urandom)};
         end
         op = $urandom_range(0, 2);
         access(op != 1, op != 0, a, $urandom, 4'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            step();
            chk_eq("gap_idle", 32'(busy), 32'd0);
         end
      end

      // LATENCY=1 with memory_read held high: a pulse every third cycle
      memory_read1 = 1'b1;
      for (int t = 0; t < 12; t++) begin
         chk_eq("l1_done", 32'(write_done1), 32'((t % 3) == 2));
         chk_eq("l1_busy", 32'(busy1), 32'((t % 3) != 0));
         chk_eq("l1_fault", 32'(access_fault1), 32'd0);
         step();
      end
      memory_read1 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
